// File: rtl/counter_pkg.sv
// Shared types and constants for the BCD countdown timer.
// State encoding, digit limit and a digit clamp helper.
package counter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

    function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One mod-10 down-counting BCD digit with loadable preset.
// Borrow ripples out when the digit sits at 0 and is asked to step.
module bcd_down_digit
    import counter_pkg::*;
(
    input  logic       i_clock,
    input  logic       i_reset_n,
    input  logic       i_load,
    input  logic [3:0] i_load_digit,
    input  logic       i_borrow_in,
    output logic [3:0] o_digit,
    output logic       o_borrow_out
);

    logic [3:0] r_digit;

    // Digit register: reset, clamped load, or one BCD step down
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_digit <= 4'd0;
        end else if (i_load) begin
            r_digit <= bcd_clamp(i_load_digit);
        end else if (i_borrow_in) begin
            r_digit <= (r_digit == 4'd0) ? BCD_MAX : r_digit - 4'd1;
        end
    end

    assign o_digit      = r_digit;
    assign o_borrow_out = i_borrow_in & (r_digit == 4'd0);

endmodule

// File: rtl/bcd_countdown_timer.sv
// Loadable multi-digit BCD countdown timer with prescaler and
// IDLE/RUN/PAUSE/DONE control; the count halts at zero.
module bcd_countdown_timer
    import counter_pkg::*;
#(
    parameter int DIGITS  = 2,
    parameter int CLK_DIV = 50000000,
    parameter int DIV_W   = 26
) (
    input  logic                  i_clock,
    input  logic                  i_reset_n,
    input  logic                  i_load,
    input  logic [4*DIGITS-1:0]   i_load_value,
    input  logic                  i_start,
    input  logic                  i_pause,
    output logic [4*DIGITS-1:0]   o_bcd,
    output logic                  o_running,
    output logic                  o_paused,
    output logic                  o_done,
    output logic                  o_done_pulse
);

    localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [4*DIGITS-1:0] BCD_ONE  = (4*DIGITS)'(1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [DIV_W-1:0]    r_presc;
    logic [DIV_W-1:0]    w_presc_nxt;
    logic                r_done_pulse;
    logic                w_dec;
    logic [4*DIGITS-1:0] w_bcd;
    logic [DIGITS:0]     w_borrow;

    assign w_borrow[0] = w_dec;

    generate
        for (genvar g = 0; g < DIGITS; g++) begin : g_digit
            bcd_down_digit u_digit (
                .i_clock      (i_clock),
                .i_reset_n    (i_reset_n),
                .i_load       (i_load),
                .i_load_digit (i_load_value[4*g +: 4]),
                .i_borrow_in  (w_borrow[g]),
                .o_digit      (w_bcd[4*g +: 4]),
                .o_borrow_out (w_borrow[g+1])
            );
        end
    endgenerate

    // Next-state, prescaler and decrement-enable decode
    always_comb begin
        w_state_nxt = r_state;
        w_presc_nxt = r_presc;
        w_dec       = 1'b0;
        if (i_load) begin
            w_state_nxt = ST_IDLE;
            w_presc_nxt = '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        w_presc_nxt = '0;
                        w_state_nxt = (w_bcd != '0) ? ST_RUN : ST_DONE;
                    end
                end
                ST_RUN: begin
                    if (i_pause) begin
                        w_state_nxt = ST_PAUSE;
                    end else if (r_presc == DIV_LAST) begin
                        w_presc_nxt = '0;
                        w_dec       = 1'b1;
                        if (w_bcd == BCD_ONE) begin
                            w_state_nxt = ST_DONE;
                        end
                    end else begin
                        w_presc_nxt = r_presc + 1'b1;
                    end
                    // A borrow out of the top digit means the count was
                    // already zero; stop rather than show 99..9 for long.
                    if (w_borrow[DIGITS]) begin
                        w_state_nxt = ST_DONE;
                    end
                end
                ST_PAUSE: begin
                    if (i_start) begin
                        w_state_nxt = ST_RUN;
                    end
                end
                ST_DONE: begin
                    w_state_nxt = ST_DONE;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // State, prescaler and terminal-count pulse registers
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_state      <= ST_IDLE;
            r_presc      <= '0;
            r_done_pulse <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_presc      <= w_presc_nxt;
            r_done_pulse <= (r_state != ST_DONE) &&
                            (w_state_nxt == ST_DONE);
        end
    end

    assign o_bcd        = w_bcd;
    assign o_running    = (r_state == ST_RUN);
    assign o_paused     = (r_state == ST_PAUSE);
    assign o_done       = (r_state == ST_DONE);
    assign o_done_pulse = r_done_pulse;

endmodule
